// File: rtl/booth_r4_pp_sequencer.sv
// Radix-4 Booth partial-product sequencer: latches one signed operand pair and
// streams the NPP sign-extended partial products over a valid/ready interface.
module booth_r4_pp_sequencer #(
  parameter int WIDTH = 32,
  parameter int NPP   = WIDTH / 2,
  parameter int PPW   = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             pp_valid,
  input  logic             pp_ready,
  output logic [PPW-1:0]   pp,
  output logic [3:0]       pp_idx,
  output logic             pp_last,
  output logic             pp_zero,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [PPW-1:0]   pp_q;
  logic [3:0]       idx_q;
  logic             last_q, zero_q;
  logic             accept, hs;

  // Returns {zero_digit, partial_product} for digit j of multiplier mb.
  function automatic logic [PPW:0] booth_pp(input logic [WIDTH-1:0] ma,
                                            input logic [WIDTH-1:0] mb,
                                            input logic [3:0]       j);
    logic [WIDTH:0] bx;
    logic [2:0]     t;
    logic [PPW-1:0] ax, m;
    bx = {mb, 1'b0} >> {j, 1'b0};
    t  = bx[2:0];
    ax = {{(PPW-WIDTH){ma[WIDTH-1]}}, ma};
    case (t)
      3'b001, 3'b010: m = ax;
      3'b011:         m = ax << 1;
      3'b100:         m = -(ax << 1);
      3'b101, 3'b110: m = -ax;
      default:        m = '0;
    endcase
    return {(t == 3'b000) || (t == 3'b111), m << {j, 1'b0}};
  endfunction

  assign in_ready = (state == IDLE);
  assign pp_valid = (state == RUN);
  assign busy     = (state == RUN);
  assign accept   = in_valid && in_ready;
  assign hs       = pp_valid && pp_ready;

  assign pp      = pp_q;
  assign pp_idx  = idx_q;
  assign pp_last = last_q;
  assign pp_zero = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = RUN;
      RUN:     if (pp_ready && last_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      pp_q   <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_q             <= a;
      b_q             <= b;
      {zero_q, pp_q}  <= booth_pp(a, b, 4'd0);
      idx_q           <= '0;
      last_q          <= (NPP == 1);
    end else if (hs) begin
      if (!last_q) begin
        idx_q          <= idx_q + 4'd1;
        {zero_q, pp_q} <= booth_pp(a_q, b_q, idx_q + 4'd1);
        last_q         <= ((idx_q + 4'd1) == 4'(NPP - 1));
      end else begin
        // Park the bus at zero between operations.
        idx_q  <= '0;
        pp_q   <= '0;
        last_q <= 1'b0;
        zero_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_r4_pp_sequencer.sv
// Scoreboard bench for booth_r4_pp_sequencer: model-generated expected pps are
// queued at operand accept and checked by a monitor on each pp handshake.
module tb_booth_r4_pp_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic        pp_valid, pp_ready;
  logic [63:0] pp;
  logic [3:0]  pp_idx;
  logic        pp_last, pp_zero, busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [63:0] pp;
    logic [3:0]  idx;
    logic        zero;
    logic        last;
    logic [63:0] prod;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [63:0] sum_acc;
  logic [63:0] last_sum;

  booth_r4_pp_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp(pp), .pp_idx(pp_idx),
    .pp_last(pp_last), .pp_zero(pp_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: digit = -2*b[2j+1] + b[2j] + b[2j-1]; pp = digit*a*4^j.
  task automatic push_op(input logic [31:0] ma, input logic [31:0] mb);
    exp_t x;
    longint d, p;
    for (int j = 0; j < 16; j++) begin
      d = -2 * longint'(mb[2*j+1]) + longint'(mb[2*j]);
      if (j > 0) d = d + longint'(mb[2*j-1]);
      p = d * longint'($signed(ma));
      x.pp   = 64'(p) << (2 * j);
      x.idx  = 4'(j);
      x.zero = (d == 0);
      x.last = (j == 15);
      x.prod = 64'(longint'($signed(ma)) * longint'($signed(mb)));
      q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) sum_acc = '0;
    else if (pp_valid && pp_ready) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pp: idx=%0d pp=%h, required no pp", pp_idx, pp);
      end else begin
        e = q.pop_front();
        checks += 4;
        if (pp_idx !== e.idx) begin
          fails++; $display("FAIL pp_idx: got %0d, required %0d", pp_idx, e.idx);
        end
        if (pp !== e.pp) begin
          fails++; $display("FAIL pp idx%0d: got %h, required %h", e.idx, pp, e.pp);
        end
        if (pp_zero !== e.zero) begin
          fails++; $display("FAIL pp_zero idx%0d: got %b, required %b", e.idx, pp_zero, e.zero);
        end
        if (pp_last !== e.last) begin
          fails++; $display("FAIL pp_last idx%0d: got %b, required %b", e.idx, pp_last, e.last);
        end
        sum_acc = sum_acc + pp;
        if (e.last) begin
          checks++;
          if (sum_acc !== e.prod) begin
            fails++; $display("FAIL pp_sum: got %h, required %h", sum_acc, e.prod);
          end
          last_sum = sum_acc;
          sum_acc  = '0;
        end
      end
    end
  end

  // Present one operand pair for a single accept; ok=0 if never ready.
  task automatic start_op(input logic [31:0] ma, input logic [31:0] mb, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      in_valid = 1'b1; a = ma; b = mb;
      push_op(ma, mb);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input bit rand_ready, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      if (rand_ready) pp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    pp_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; pp_ready = 1'b1; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (pp_valid !== 1'b0) begin fails++; $display("FAIL rst_pp_valid: got %b, required 0", pp_valid); end
    if (pp !== 64'd0)      begin fails++; $display("FAIL rst_pp: got %h, required 0", pp); end
    if (pp_idx !== 4'd0)   begin fails++; $display("FAIL rst_pp_idx: got %0d, required 0", pp_idx); end
    if (pp_last !== 1'b0)  begin fails++; $display("FAIL rst_pp_last: got %b, required 0", pp_last); end
    if (pp_zero !== 1'b0)  begin fails++; $display("FAIL rst_pp_zero: got %b, required 0", pp_zero); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL rst_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_directed;
    logic [31:0] va[4] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7};
    logic [31:0] vb[4] = '{32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [63:0] vs[4] = '{64'd15, 64'h0000_0000_8000_0000, 64'h4000_0000_0000_0000,
                           64'hFFFF_FFFF_FFFF_FFF9};
    bit ok;
    for (int i = 0; i < 4; i++) begin
      last_sum = 'x;
      start_op(va[i], vb[i], ok);
      if (ok) wait_idle(1'b0, ok);
      checks += 3;
      if (!ok) begin fails++; $display("FAIL directed%0d_timeout: got no completion, required done", i); end
      if (last_sum !== vs[i]) begin
        fails++; $display("FAIL directed%0d_sum: got %h, required %h", i, last_sum, vs[i]);
      end
      if (q.size() != 0) begin
        fails++; $display("FAIL directed%0d_count: got %0d pps missing, required 0", i, q.size());
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok, found;
    logic [63:0] snap;
    start_op(32'hFFFF_CFC7, 32'h5A5A_5A5A, ok);
    found = 1'b0;
    for (int i = 0; i < 30 && ok; i++) begin
      if (pp_valid && pp_idx == 4'd5) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL bp_reach_idx5: got idx %0d, required 5", pp_idx); end
    pp_ready = 1'b0;
    snap = pp;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks += 3;
      if (pp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid%0d: got %b, required 1", c, pp_valid); end
      if (pp !== snap) begin fails++; $display("FAIL bp_pp%0d: got %h, required %h", c, pp, snap); end
      if (pp_idx !== 4'd5) begin fails++; $display("FAIL bp_idx%0d: got %0d, required 5", c, pp_idx); end
    end
    pp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (pp_idx !== 4'd6) begin fails++; $display("FAIL bp_resume_idx: got %0d, required 6", pp_idx); end
    wait_idle(1'b0, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL bp_timeout: got no completion, required done"); end
  endtask

  task automatic test_reset_midop;
    bit ok, found;
    start_op(32'hFFFF_FF9D, 32'd12345, ok);
    found = 1'b0;
    for (int i = 0; i < 30 && ok; i++) begin
      if (pp_valid && pp_idx == 4'd7) begin found = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL rm_reach_idx7: got idx %0d, required 7", pp_idx); end
    rst_n = 1'b0;
    #1;
    q.delete();
    checks += 3;
    if (pp_valid !== 1'b0) begin fails++; $display("FAIL rm_pp_valid: got %b, required 0", pp_valid); end
    if (busy !== 1'b0)     begin fails++; $display("FAIL rm_busy: got %b, required 0", busy); end
    if (pp !== 64'd0)      begin fails++; $display("FAIL rm_pp: got %h, required 0", pp); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rm_in_ready: got %b, required 1", in_ready); end
    last_sum = 'x;
    start_op(32'd1000, 32'hFFFF_FC18, ok);
    if (ok) wait_idle(1'b0, ok);
    checks += 2;
    if (!ok) begin fails++; $display("FAIL rm_timeout: got no completion, required done"); end
    if (last_sum !== 64'hFFFF_FFFF_FFF0_BDC0) begin
      fails++; $display("FAIL rm_sum: got %h, required %h", last_sum, 64'hFFFF_FFFF_FFF0_BDC0);
    end
  endtask

  task automatic test_back_to_back;
    int t[3];
    int n = 0;
    int cyc = 0;
    bit ok;
    a = 32'h1234_5678; b = 32'hFFFF_FFFD; pp_ready = 1'b1;
    for (int k = 0; k < 3; k++) push_op(a, b);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        t[n] = cyc; n++;
        if (n == 3) begin @(posedge clk); #1; break; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (n != 3) begin
      fails++; $display("FAIL b2b_accepts: got %0d, required 3", n);
    end else begin
      checks += 2;
      if (t[1] - t[0] != 17) begin fails++; $display("FAIL b2b_gap0: got %0d, required 17", t[1] - t[0]); end
      if (t[2] - t[1] != 17) begin fails++; $display("FAIL b2b_gap1: got %0d, required 17", t[2] - t[1]); end
    end
    wait_idle(1'b0, ok);
    checks += 2;
    if (!ok) begin fails++; $display("FAIL b2b_timeout: got no completion, required done"); end
    if (q.size() != 0) begin fails++; $display("FAIL b2b_count: got %0d pps missing, required 0", q.size()); end
  endtask

  task automatic test_random;
    bit ok;
    logic [31:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 97 == 0) ra = 32'h8000_0000;
      if (i % 89 == 0) rb = 32'h7FFF_FFFF;
      start_op(ra, rb, ok);
      if (ok) wait_idle(1'b1, ok);
      checks++;
      if (!ok || q.size() != 0) begin
        fails++; $display("FAIL rand%0d_done: ok=%b left=%0d, required ok=1 left=0", i, ok, q.size());
        q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
